// File: rtl/overlay_sprite_engine_pkg.sv
// Shared constants for the overlay sprite engine: geometry/pixel widths,
// board colours, default key thresholds and the transparency-key function.
package overlay_sprite_engine_pkg;

  localparam int RESO_W = 10;
  localparam int PX_W   = 12;

  localparam logic [PX_W-1:0] COL_BOARD_BACK = 12'hdb8;
  localparam logic [PX_W-1:0] COL_LINE       = 12'h000;
  localparam logic [PX_W-1:0] COL_BLUE       = 12'h00f;
  localparam logic [PX_W-1:0] COL_RED        = 12'hf00;

  localparam logic [3:0]      DEF_LIM_R    = 4'h8;
  localparam logic [3:0]      DEF_LIM_G    = 4'h6;
  localparam logic [3:0]      DEF_LIM_B    = 4'h4;
  localparam logic [PX_W-1:0] DEF_KEY_DARK = 12'h222;

  // Light-key drops near-white paper; dark-key drops near-black background.
  function automatic logic is_transparent(input logic [PX_W-1:0] px,
                                          input logic            dark_mode,
                                          input logic [3:0]      lim_r,
                                          input logic [3:0]      lim_g,
                                          input logic [3:0]      lim_b,
                                          input logic [PX_W-1:0] key_dark);
    if (dark_mode)
      return px <= key_dark;
    return (px[11:8] > lim_r) && (px[7:4] > lim_g) && (px[3:0] > lim_b);
  endfunction

endpackage

// File: rtl/overlay_sprite_engine_channel_ctr.sv
// Per-window hit compare and linear ROM pointer; the pointer trails the
// raster by one cycle and is armed by the first origin pixel after reset.
module overlay_channel_ctr
  import overlay_sprite_engine_pkg::*;
#(
  parameter int              ADDR_W = 12,
  parameter logic [RESO_W-1:0] X0     = '0,
  parameter logic [RESO_W-1:0] Y0     = '0,
  parameter logic [RESO_W-1:0] W      = 10'd15,
  parameter logic [RESO_W-1:0] H      = 10'd100,
  parameter logic              ROT180 = 1'b0
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic [RESO_W-1:0] h_cnt,
  input  logic [RESO_W-1:0] v_cnt,
  output logic              hit,
  output logic              armed_eff,
  output logic [ADDR_W-1:0] ptr
);

  localparam int              AREA = int'(W) * int'(H);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(AREA - 1);

  logic armed;
  logic origin;
  logic in_x;
  logic in_y;

  assign in_x   = (h_cnt >= X0) && ({1'b0, h_cnt} < ({1'b0, X0} + {1'b0, W}));
  assign in_y   = (v_cnt >= Y0) && ({1'b0, v_cnt} < ({1'b0, Y0} + {1'b0, H}));
  assign hit    = in_x && in_y;
  assign origin = (h_cnt == X0) && (v_cnt == Y0);
  // The origin pixel itself qualifies, before the armed flop has updated.
  assign armed_eff = armed || origin;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      armed <= 1'b0;
    end else if (origin) begin
      ptr   <= ROT180 ? LAST : '0;
      armed <= 1'b1;
    end else if (hit) begin
      ptr   <= ROT180 ? ptr - 1'b1 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/overlay_sprite_engine.sv
// Multi-window sprite overlay: per-channel ROM addressing, latency-aligned
// keying with blink gating, and a lowest-index-wins priority mux.
module overlay_sprite_engine
  import overlay_sprite_engine_pkg::*;
#(
  parameter int                       N_CH        = 6,
  parameter int                       ADDR_W      = 12,
  parameter logic [RESO_W*N_CH-1:0]   CH_X0       = {N_CH{10'd0}},
  parameter logic [RESO_W*N_CH-1:0]   CH_Y0       = {N_CH{10'd0}},
  parameter logic [RESO_W*N_CH-1:0]   CH_W        = {N_CH{10'd15}},
  parameter logic [RESO_W*N_CH-1:0]   CH_H        = {N_CH{10'd100}},
  parameter logic [N_CH-1:0]          CH_ROT180   = '0,
  parameter logic [N_CH-1:0]          CH_KEY_MODE = '0,
  parameter logic [3:0]               LIM_R       = DEF_LIM_R,
  parameter logic [3:0]               LIM_G       = DEF_LIM_G,
  parameter logic [3:0]               LIM_B       = DEF_LIM_B,
  parameter logic [PX_W-1:0]          KEY_DARK    = DEF_KEY_DARK,
  parameter int                       ROM_LAT     = 1,
  parameter int                       BLINK_SHIFT = 5
) (
  input  logic                     vga_clk,
  input  logic                     rst_n,
  input  logic [RESO_W-1:0]        h_cnt,
  input  logic [RESO_W-1:0]        v_cnt,
  input  logic [N_CH-1:0]          ch_en,
  input  logic [N_CH-1:0]          ch_blink,
  output logic [N_CH*ADDR_W-1:0]   rom_addr,
  input  logic [N_CH*PX_W-1:0]     rom_data,
  output logic                     ovl_valid,
  output logic [PX_W-1:0]          ovl_px,
  output logic [2:0]               ovl_ch
);

  logic [N_CH-1:0]              hit;
  logic [N_CH-1:0]              armed_eff;
  logic [N_CH-1:0]              q_hit;
  logic [ROM_LAT:0][N_CH-1:0]   q_pipe;
  logic [7:0]                   frame_cnt;
  logic                         blink_on;
  logic                         win_valid;
  logic [PX_W-1:0]              win_px;
  logic [2:0]                   win_ch;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    overlay_channel_ctr #(
      .ADDR_W (ADDR_W),
      .X0     (CH_X0[RESO_W*i +: RESO_W]),
      .Y0     (CH_Y0[RESO_W*i +: RESO_W]),
      .W      (CH_W[RESO_W*i +: RESO_W]),
      .H      (CH_H[RESO_W*i +: RESO_W]),
      .ROT180 (CH_ROT180[i])
    ) u_ctr (
      .vga_clk   (vga_clk),
      .rst_n     (rst_n),
      .h_cnt     (h_cnt),
      .v_cnt     (v_cnt),
      .hit       (hit[i]),
      .armed_eff (armed_eff[i]),
      .ptr       (rom_addr[ADDR_W*i +: ADDR_W])
    );
  end

  assign blink_on = frame_cnt[BLINK_SHIFT];
  assign q_hit    = hit & armed_eff & ch_en & ~(ch_blink & {N_CH{~blink_on}});

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      q_pipe    <= '0;
    end else begin
      if (h_cnt == '0 && v_cnt == '0)
        frame_cnt <= frame_cnt + 8'd1;
      // One stage for the pointer register plus ROM_LAT stages for the ROM.
      q_pipe <= {q_pipe[ROM_LAT-1:0], q_hit};
    end
  end

  // Scan from the top index down so the lowest opaque channel is written last.
  always_comb begin
    win_valid = 1'b0;
    win_px    = '0;
    win_ch    = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (q_pipe[ROM_LAT][i] &&
          !is_transparent(rom_data[PX_W*i +: PX_W], CH_KEY_MODE[i],
                          LIM_R, LIM_G, LIM_B, KEY_DARK)) begin
        win_valid = 1'b1;
        win_px    = rom_data[PX_W*i +: PX_W];
        win_ch    = 3'(i);
      end
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      ovl_valid <= 1'b0;
      ovl_px    <= '0;
      ovl_ch    <= '0;
    end else begin
      ovl_valid <= win_valid;
      ovl_px    <= win_px;
      ovl_ch    <= win_ch;
    end
  end

endmodule

// File: tb/tb_overlay_sprite_engine.sv
// Bench for overlay_sprite_engine: raster pixels are driven directly, a
// reference model queues the expected overlay per pixel, popped three cycles later.
module tb_overlay_sprite_engine;

  localparam int N = 6;

  logic          vga_clk = 1'b0;
  logic          rst_n;
  logic [9:0]    h_cnt, v_cnt;
  logic [5:0]    ch_en, ch_blink;
  logic [71:0]   rom_addr;
  logic [71:0]   rom_data;
  logic          ovl_valid;
  logic [11:0]   ovl_px;
  logic [2:0]    ovl_ch;

  int gx0 [6] = '{118, 120, 118, 600, 300, 700};
  int gy0 [6] = '{37, 40, 37, 400, 200, 500};
  int gw  [6] = '{15, 10, 15, 4, 4, 2};
  int gh  [6] = '{100, 10, 100, 4, 4, 2};

  overlay_sprite_engine #(
    .N_CH        (6),
    .ADDR_W      (12),
    .CH_X0       ({10'd700, 10'd300, 10'd600, 10'd118, 10'd120, 10'd118}),
    .CH_Y0       ({10'd500, 10'd200, 10'd400, 10'd37, 10'd40, 10'd37}),
    .CH_W        ({10'd2, 10'd4, 10'd4, 10'd15, 10'd10, 10'd15}),
    .CH_H        ({10'd2, 10'd4, 10'd4, 10'd100, 10'd10, 10'd100}),
    .CH_ROT180   (6'b000100),
    .CH_KEY_MODE (6'b010000),
    .ROM_LAT     (1),
    .BLINK_SHIFT (1)
  ) dut (
    .vga_clk   (vga_clk),
    .rst_n     (rst_n),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .ch_en     (ch_en),
    .ch_blink  (ch_blink),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .ovl_valid (ovl_valid),
    .ovl_px    (ovl_px),
    .ovl_ch    (ovl_ch)
  );

  always #5 vga_clk = ~vga_clk;

  // One-cycle-latency ROM returning a fixed pixel per channel.
  logic [11:0] tbl [6];
  always @(posedge vga_clk)
    for (int i = 0; i < N; i++) rom_data[i*12 +: 12] <= tbl[i];

  typedef struct packed {
    logic        v;
    logic [11:0] px;
    logic [2:0]  ch;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         valid_seen = 0;
  logic [5:0] armed_m = '0;
  logic [7:0] fc = '0;

  function automatic logic model_transp(input int i, input logic [11:0] p);
    if (i == 4) return p <= 12'h222;
    return (p[11:8] > 4'h8) && (p[7:4] > 4'h6) && (p[3:0] > 4'h4);
  endfunction

  task automatic model_push(input int h, input int v);
    exp_t e;
    logic hit, orig, q;
    e = '0;
    for (int i = 0; i < N; i++) begin
      hit  = (h >= gx0[i]) && (h < gx0[i] + gw[i]) && (v >= gy0[i]) && (v < gy0[i] + gh[i]);
      orig = (h == gx0[i]) && (v == gy0[i]);
      q    = hit && (armed_m[i] || orig) && ch_en[i] && !(ch_blink[i] && !fc[1]);
      if (orig) armed_m[i] = 1'b1;
      if (q && !e.v && !model_transp(i, tbl[i])) begin
        e.v  = 1'b1;
        e.px = tbl[i];
        e.ch = 3'(i);
      end
    end
    if (h == 0 && v == 0) fc = fc + 8'd1;
    sb.push_back(e);
  endtask

  task automatic cycle(input int h, input int v);
    exp_t e;
    @(negedge vga_clk);
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    model_push(h, v);
    @(posedge vga_clk);
    #1;
    if (sb.size() >= 3) begin
      e = sb.pop_front();
      vectors++;
      if (ovl_valid !== e.v || ovl_px !== e.px || ovl_ch !== e.ch) begin
        miscompares++;
        $display("FAIL sb_pixel t=%0t: got v=%b px=%h ch=%0d, expected v=%b px=%h ch=%0d",
                 $time, ovl_valid, ovl_px, ovl_ch, e.v, e.px, e.ch);
      end
      if (ovl_valid === 1'b1) valid_seen++;
    end
  endtask

  task automatic flush();
    repeat (3) cycle(1000, 1000);
  endtask

  task automatic scan(input int c, input int y_from, input int y_to);
    for (int v = y_from; v <= y_to; v++)
      for (int h = gx0[c]; h < gx0[c] + gw[c]; h++)
        cycle(h, v);
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (ovl_valid !== 1'b0 || ovl_px !== 12'h0 || ovl_ch !== 3'd0 || rom_addr !== 72'h0) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b px=%h ch=%0d addr=%h, expected all zero",
               ovl_valid, ovl_px, ovl_ch, rom_addr);
    end
    repeat (2) @(negedge vga_clk);
    rst_n = 1'b1;
  endtask

  task automatic test_blink();
    int base;
    ch_en    = 6'b010000;
    ch_blink = 6'b010000;
    for (int f = 0; f < 6; f++) begin
      tbl[4] = 12'h223;
      flush();
      base = valid_seen;
      scan(4, gy0[4], gy0[4] + gh[4] - 1);
      flush();
      vectors++;
      if (valid_seen - base != ((f == 2 || f == 3) ? 16 : 0)) begin
        miscompares++;
        $display("FAIL blink_frame%0d: got %0d opaque pixels, expected %0d",
                 f, valid_seen - base, (f == 2 || f == 3) ? 16 : 0);
      end
      tbl[4] = 12'h222;
      flush();
      base = valid_seen;
      scan(4, gy0[4], gy0[4] + gh[4] - 1);
      flush();
      vectors++;
      if (valid_seen - base != 0) begin
        miscompares++;
        $display("FAIL darkkey_222_frame%0d: got %0d opaque pixels, expected 0", f, valid_seen - base);
      end
      cycle(0, 0);
    end
    ch_blink = '0;
  endtask

  task automatic test_addr_scan();
    int base;
    ch_en  = 6'b000001;
    tbl[0] = 12'h000;
    flush();
    base = valid_seen;
    for (int v = 37; v <= 136; v++) begin
      for (int h = 118; h <= 132; h++) begin
        cycle(h, v);
        if (v == 37 && h == 118) begin
          vectors++;
          if (rom_addr[11:0] !== 12'd0 || rom_addr[35:24] !== 12'd1499) begin
            miscompares++;
            $display("FAIL addr_origin: got ch0=%0d ch2=%0d, expected 0 and 1499",
                     rom_addr[11:0], rom_addr[35:24]);
          end
        end
        if (v == 37 && h == 132) begin
          vectors++;
          if (rom_addr[11:0] !== 12'd14) begin
            miscompares++;
            $display("FAIL addr_row_end: got %0d, expected 14", rom_addr[11:0]);
          end
        end
        if (v == 38 && h == 118) begin
          vectors++;
          if (rom_addr[11:0] !== 12'd15) begin
            miscompares++;
            $display("FAIL addr_row2: got %0d, expected 15", rom_addr[11:0]);
          end
        end
        if (v == 136 && h == 132) begin
          vectors++;
          if (rom_addr[11:0] !== 12'd1499 || rom_addr[35:24] !== 12'd0) begin
            miscompares++;
            $display("FAIL addr_last: got ch0=%0d ch2=%0d, expected 1499 and 0",
                     rom_addr[11:0], rom_addr[35:24]);
          end
        end
      end
    end
    cycle(1000, 1000);
    vectors++;
    if (rom_addr[11:0] !== 12'd1499) begin
      miscompares++;
      $display("FAIL addr_hold: got %0d, expected 1499", rom_addr[11:0]);
    end
    flush();
    vectors++;
    if (valid_seen - base != 1500) begin
      miscompares++;
      $display("FAIL scan_opaque: got %0d opaque pixels, expected 1500", valid_seen - base);
    end
  endtask

  task automatic test_light_key();
    int  base;
    logic [3:0] seen;
    ch_en  = 6'b000001;
    tbl[0] = 12'hfda;
    flush();
    base = valid_seen;
    scan(0, 37, 136);
    flush();
    vectors++;
    if (valid_seen - base != 0) begin
      miscompares++;
      $display("FAIL lightkey_fda: got %0d opaque pixels, expected 0", valid_seen - base);
    end
    tbl[0] = 12'h000;
    flush();
    cycle(118, 37);
    seen[0] = ovl_valid;
    cycle(1000, 1000);
    seen[1] = ovl_valid;
    cycle(1000, 1000);
    seen[2] = ovl_valid;
    cycle(1000, 1000);
    seen[3] = ovl_valid;
    vectors++;
    if (seen !== 4'b0100) begin
      miscompares++;
      $display("FAIL latency: got valid pattern %b over cycles 3..0 after pixel, expected 0100", seen);
    end
  endtask

  task automatic test_priority();
    int base;
    ch_en  = 6'b000011;
    tbl[0] = 12'hfda;
    tbl[1] = 12'hf33;
    flush();
    base = valid_seen;
    scan(0, 37, 136);
    flush();
    vectors++;
    if (valid_seen - base != 100) begin
      miscompares++;
      $display("FAIL prio_fallthrough: got %0d opaque pixels, expected 100", valid_seen - base);
    end
    tbl[0] = 12'h39f;
    flush();
    base = valid_seen;
    scan(0, 37, 136);
    flush();
    vectors++;
    if (valid_seen - base != 1500) begin
      miscompares++;
      $display("FAIL prio_ch0_wins: got %0d opaque pixels, expected 1500", valid_seen - base);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    ch_en  = 6'b000001;
    tbl[0] = 12'h000;
    flush();
    scan(0, 37, 86);
    @(negedge vga_clk);
    rst_n = 1'b0;
    sb.delete();
    armed_m = '0;
    fc = '0;
    #1;
    vectors++;
    if (ovl_valid !== 1'b0 || ovl_px !== 12'h0 || ovl_ch !== 3'd0 || rom_addr !== 72'h0) begin
      miscompares++;
      $display("FAIL reset_mid: got v=%b px=%h ch=%0d addr=%h, expected all zero",
               ovl_valid, ovl_px, ovl_ch, rom_addr);
    end
    repeat (3) @(negedge vga_clk);
    rst_n = 1'b1;
    base = valid_seen;
    scan(0, 87, 136);
    flush();
    vectors++;
    if (valid_seen - base != 0) begin
      miscompares++;
      $display("FAIL unarmed_suppress: got %0d opaque pixels, expected 0", valid_seen - base);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(118 + k, 37);
      vectors++;
      if (rom_addr[11:0] !== 12'(k)) begin
        miscompares++;
        $display("FAIL rearm_addr%0d: got %0d, expected %0d", k, rom_addr[11:0], k);
      end
    end
    flush();
  endtask

  initial begin
    rst_n    = 1'b0;
    h_cnt    = 10'd1000;
    v_cnt    = 10'd1000;
    ch_en    = '0;
    ch_blink = '0;
    for (int i = 0; i < N; i++) tbl[i] = 12'h000;
    test_reset();
    test_blink();
    test_addr_scan();
    test_light_key();
    test_priority();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
